mi_sequencer: RTL and testbench

//  Microprogram sequencer (control-store address unit plus MIR) for the ARC microcoded datapath.

---
 rtl/mi_sequencer.sv | 132 +++++++++++++
 tb/tb_mi_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mi_sequencer.sv
// Microprogram sequencer for the ARC microcoded datapath: CSAR, MIR and next-address selection.
// Optional single-step mode is enabled by defining MI_SEQ_SINGLE_STEP_EN.
module mi_sequencer #(
    parameter int ADDR_W = 11,
    parameter int WORD_W = 41,
    parameter int IR_W   = 32
) (
    input  logic              MI_SEQ_CLOCK_50,
    input  logic              MI_SEQ_RESET_InLow,
    input  logic [WORD_W-1:0] MI_SEQ_ROM_DATA_InBUS,
    input  logic [IR_W-1:0]   MI_SEQ_IR_InBUS,
    input  logic [3:0]        MI_SEQ_PSR_InBUS,
    input  logic              MI_SEQ_MEM_ACK_In,
`ifdef MI_SEQ_SINGLE_STEP_EN
    input  logic              MI_SEQ_STEP_In,
`endif
    output logic [ADDR_W-1:0] MI_SEQ_ROM_ADDR_OutBUS,
    output logic [WORD_W-1:0] MI_SEQ_MIR_OutBUS,
    output logic              MI_SEQ_EXEC_Out,
    output logic              MI_SEQ_MEM_REQ_Out
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   csar_q, csar_d;
    logic [WORD_W-1:0]   mir_q, mir_d;
    logic [ADDR_W-1:0]   jump_addr;
    logic [ADDR_W-1:0]   decode_addr;
    logic [ADDR_W-1:0]   nxt_addr;
    logic [2:0]          cond;
    logic                mem_op;
    logic                unused_ir;

    assign cond        = mir_q[13:11];
    assign mem_op      = mir_q[19] | mir_q[18];
    assign jump_addr   = ADDR_W'(mir_q[10:0]);
    assign decode_addr = ADDR_W'({1'b1, MI_SEQ_IR_InBUS[31:30], MI_SEQ_IR_InBUS[24:19], 2'b00});
    assign unused_ir   = ^{MI_SEQ_IR_InBUS[29:25], MI_SEQ_IR_InBUS[18:14], MI_SEQ_IR_InBUS[12:0]};

    // Flags and IR are the values present in the advancing cycle, i.e. before this word's own writes land.
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] csar,
        input logic [2:0]        cnd,
        input logic [ADDR_W-1:0] jmp,
        input logic [ADDR_W-1:0] dec,
        input logic [3:0]        psr,
        input logic              ir13
    );
        logic [ADDR_W-1:0] inc;
        inc = csar + ADDR_W'(1);
        case (cnd)
            3'b000:  next_addr = inc;
            3'b001:  next_addr = psr[3] ? jmp : inc;
            3'b010:  next_addr = psr[2] ? jmp : inc;
            3'b011:  next_addr = psr[1] ? jmp : inc;
            3'b100:  next_addr = psr[0] ? jmp : inc;
            3'b101:  next_addr = ir13   ? jmp : inc;
            3'b110:  next_addr = jmp;
            default: next_addr = dec;
        endcase
    endfunction

    assign nxt_addr = next_addr(csar_q, cond, jump_addr, decode_addr,
                                MI_SEQ_PSR_InBUS, MI_SEQ_IR_InBUS[13]);

    always_ff @(posedge MI_SEQ_CLOCK_50) begin
        if (!MI_SEQ_RESET_InLow) begin
            state_q <= S_LOAD;
            csar_q  <= '0;
            mir_q   <= '0;
        end else begin
            state_q <= state_d;
            csar_q  <= csar_d;
            mir_q   <= mir_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        csar_d             = csar_q;
        mir_d              = mir_q;
        MI_SEQ_EXEC_Out    = 1'b0;
        MI_SEQ_MEM_REQ_Out = 1'b0;
        case (state_q)
            S_LOAD: begin
`ifdef MI_SEQ_SINGLE_STEP_EN
                if (MI_SEQ_STEP_In) begin
                    mir_d   = MI_SEQ_ROM_DATA_InBUS;
                    state_d = S_EXEC;
                end
`else
                mir_d   = MI_SEQ_ROM_DATA_InBUS;
                state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                if (mem_op) begin
                    MI_SEQ_MEM_REQ_Out = 1'b1;
                    MI_SEQ_EXEC_Out    = MI_SEQ_MEM_ACK_In;
                    if (MI_SEQ_MEM_ACK_In) begin
                        csar_d  = nxt_addr;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    MI_SEQ_EXEC_Out = 1'b1;
                    csar_d          = nxt_addr;
                    state_d         = S_LOAD;
                end
            end
            S_WAIT: begin
                MI_SEQ_MEM_REQ_Out = 1'b1;
                MI_SEQ_EXEC_Out    = MI_SEQ_MEM_ACK_In;
                if (MI_SEQ_MEM_ACK_In) begin
                    csar_d  = nxt_addr;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign MI_SEQ_ROM_ADDR_OutBUS = csar_q;
    assign MI_SEQ_MIR_OutBUS      = mir_q;

endmodule

// File: tb/tb_mi_sequencer.sv
// Scoreboard bench for mi_sequencer: a ROM image drives directed microprogram walks, a monitor checks every EXEC.
// With MI_SEQ_SINGLE_STEP_EN defined, STEP is held high so the same walks apply.
module tb_mi_sequencer;
    localparam int ADDR_W = 11;
    localparam int WORD_W = 41;
    localparam int IR_W   = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [WORD_W-1:0] rom_data;
    logic [IR_W-1:0]   ir;
    logic [3:0]        psr;
    logic              mem_ack = 1'b0;
`ifdef MI_SEQ_SINGLE_STEP_EN
    logic              step = 1'b1;
`endif
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] mir;
    logic              exec;
    logic              mem_req;

    logic [WORD_W-1:0] rom [0:2047];

    typedef struct {
        logic [10:0] addr;
        logic [40:0] word;
        int          gap;
        int          req;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   rd_delay = 3;
    int   req_cnt = 0;
    int   gap = 0;
    int   req_run = 0;
    logic [10:0] req_addr = '0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    mi_sequencer #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .IR_W(IR_W)) dut (
        .MI_SEQ_CLOCK_50       (clk),
        .MI_SEQ_RESET_InLow    (rst_n),
        .MI_SEQ_ROM_DATA_InBUS (rom_data),
        .MI_SEQ_IR_InBUS       (ir),
        .MI_SEQ_PSR_InBUS      (psr),
        .MI_SEQ_MEM_ACK_In     (mem_ack),
`ifdef MI_SEQ_SINGLE_STEP_EN
        .MI_SEQ_STEP_In        (step),
`endif
        .MI_SEQ_ROM_ADDR_OutBUS(rom_addr),
        .MI_SEQ_MIR_OutBUS     (mir),
        .MI_SEQ_EXEC_Out       (exec),
        .MI_SEQ_MEM_REQ_Out    (mem_req)
    );

    function automatic logic [40:0] mw(input logic [5:0] tag, input logic rd, input logic wr,
                                       input logic [2:0] cond, input logic [10:0] jump);
        mw = {tag, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, rd, wr, 4'd0, cond, jump};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic [10:0] a, input int g, input int r);
        exp_t e;
        e.addr = a;
        e.word = rom[a];
        e.gap  = g;
        e.req  = r;
        sb.push_back(e);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
            sb.delete();
        end
    endtask

    // Memory responder: WR acks in the request cycle, RD acks rd_delay cycles after S_EXEC entry.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (rst_n && mem_req) begin
            if (req_cnt == (mir[18] ? 0 : rd_delay)) mem_ack = 1'b1;
            req_cnt++;
        end else begin
            req_cnt = 0;
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            gap     = 0;
            req_run = 0;
        end else begin
            gap++;
            if (mem_req) begin
                if (req_run == 0) req_addr = rom_addr;
                else chk("csar_frozen", 64'(rom_addr), 64'(req_addr));
                req_run++;
            end
            if (exec) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_exec actual_addr=%0d required=no_exec", rom_addr);
                end else begin
                    mon_e = sb.pop_front();
                    chk("exec_addr", 64'(rom_addr), 64'(mon_e.addr));
                    chk("exec_mir",  64'(mir),      64'(mon_e.word));
                    chk("exec_gap",  64'(gap),      64'(mon_e.gap));
                    chk("req_len",   64'(req_run),  64'(mon_e.req));
                end
                gap = 0;
            end
            if (!mem_req || exec) req_run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        for (int i = 0; i < 2048; i++) rom[i] = '0;
        for (int i = 0; i < 2048; i++) rom[i][40:35] = 6'(i + 1);
        rom[0]    = mw(6'd1,  1'b0, 1'b0, 3'b000, 11'd0);
        rom[1]    = mw(6'd2,  1'b0, 1'b0, 3'b111, 11'd0);
        rom[1600] = mw(6'd3,  1'b0, 1'b0, 3'b010, 11'd12);
        rom[12]   = mw(6'd4,  1'b0, 1'b0, 3'b001, 11'd100);
        rom[13]   = mw(6'd5,  1'b0, 1'b0, 3'b011, 11'd200);
        rom[200]  = mw(6'd6,  1'b0, 1'b0, 3'b100, 11'd300);
        rom[201]  = mw(6'd7,  1'b0, 1'b0, 3'b101, 11'd300);
        rom[300]  = mw(6'd8,  1'b1, 1'b0, 3'b110, 11'd400);
        rom[400]  = mw(6'd9,  1'b0, 1'b1, 3'b000, 11'd0);
        rom[401]  = mw(6'd10, 1'b0, 1'b0, 3'b110, 11'd0);
        rom[1624] = mw(6'd11, 1'b0, 1'b0, 3'b110, 11'd8);
        rom[8]    = mw(6'd12, 1'b0, 1'b0, 3'b010, 11'd12);
        rom[9]    = mw(6'd13, 1'b0, 1'b0, 3'b110, 11'd2047);
        rom[2047] = mw(6'd14, 1'b0, 1'b0, 3'b000, 11'd5);
        rom[1536] = mw(6'd15, 1'b1, 1'b0, 3'b000, 11'd0);

        // Walk 1: addcc with i=1, flags n=0 z=1 v=1 c=0; includes an RD with late ACK and a WR with immediate ACK.
        rst_n = 1'b0;
        ir    = 32'h8080_2000;
        psr   = 4'b0110;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_addr",    64'(rom_addr), 64'd0);
        chk("rst_mir",     64'(mir),      64'd0);
        chk("rst_exec",    64'(exec),     64'd0);
        chk("rst_mem_req", 64'(mem_req),  64'd0);
        push(11'd0, 2, 0);    push(11'd1, 2, 0);    push(11'd1600, 2, 0);
        push(11'd12, 2, 0);   push(11'd13, 2, 0);   push(11'd200, 2, 0);
        push(11'd201, 2, 0);  push(11'd300, 5, 4);  push(11'd400, 2, 1);
        push(11'd401, 2, 0);  push(11'd0, 2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drain(200);
        @(negedge clk);
        rst_n = 1'b0;

        // Walk 2: op3=010110 decode, z=0 fall-through, wrap from 2047.
        ir  = 32'h80B0_0000;
        psr = 4'b0000;
        repeat (3) @(negedge clk);
        push(11'd0, 2, 0);    push(11'd1, 2, 0);    push(11'd1624, 2, 0);
        push(11'd8, 2, 0);    push(11'd9, 2, 0);    push(11'd2047, 2, 0);
        push(11'd0, 2, 0);
        rst_n = 1'b1;
        drain(200);
        @(negedge clk);
        rst_n = 1'b0;

        // Walk 3: decode to an RD word that never sees ACK, then reset while waiting.
        ir       = 32'h8000_0000;
        rd_delay = 1000;
        repeat (3) @(negedge clk);
        push(11'd0, 2, 0);
        push(11'd1, 2, 0);
        rst_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 50 && cnt < 3; n++) begin
            @(negedge clk);
            #3;
            if (mem_req) cnt++;
            else cnt = 0;
        end
        chk("wait_reached", 64'(cnt),      64'd3);
        chk("wait_addr",    64'(rom_addr), 64'd1536);
        chk("wait_exec",    64'(exec),     64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #3;
        chk("wait_rst_mem_req", 64'(mem_req),  64'd0);
        chk("wait_rst_addr",    64'(rom_addr), 64'd0);
        chk("wait_rst_exec",    64'(exec),     64'd0);
        chk("wait_rst_mir",     64'(mir),      64'd0);
        chk("sb_empty",         64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
